// File: rtl/pipe_ctrl_skid.sv
// Pipeline-stage register with a valid/ready handshake, synchronous flush and an
// optional two-entry skid buffer that keeps in_ready off the out_ready path.
module pipe_ctrl_skid #(
    parameter int unsigned      WIDTH     = 3,
    parameter logic [WIDTH-1:0] FLUSH_VAL = '0,
    parameter bit               SKID      = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    logic [WIDTH-1:0] main_q;
    logic             vld_q;

    assign out_data  = main_q;
    assign out_valid = vld_q;

    generate
        if (SKID) begin : g_skid
            typedef enum logic [1:0] {
                EMPTY = 2'd0,
                ONE   = 2'd1,
                FULL  = 2'd2
            } state_t;

            state_t           state;
            logic [WIDTH-1:0] skid_q;
            logic             rdy_q;
            logic [1:0]       occ_q;
            logic             in_fire;
            logic             out_fire;

            assign in_fire   = in_valid & rdy_q;
            assign out_fire  = vld_q & out_ready;
            assign in_ready  = rdy_q;
            assign occupancy = occ_q;

            // in_ready, out_valid and occupancy are all registered next to the
            // state so none of them has a combinational path from out_ready.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state  <= EMPTY;
                    main_q <= FLUSH_VAL;
                    skid_q <= FLUSH_VAL;
                    rdy_q  <= 1'b1;
                    occ_q  <= 2'd0;
                    vld_q  <= 1'b0;
                end else if (flush) begin
                    state  <= EMPTY;
                    main_q <= FLUSH_VAL;
                    skid_q <= FLUSH_VAL;
                    rdy_q  <= 1'b1;
                    occ_q  <= 2'd0;
                    vld_q  <= 1'b0;
                end else begin
                    case (state)
                        EMPTY: begin
                            if (in_fire) begin
                                main_q <= in_data;
                                state  <= ONE;
                                occ_q  <= 2'd1;
                                vld_q  <= 1'b1;
                            end
                        end
                        ONE: begin
                            if (in_fire && out_fire) begin
                                main_q <= in_data;
                            end else if (in_fire) begin
                                skid_q <= in_data;
                                state  <= FULL;
                                rdy_q  <= 1'b0;
                                occ_q  <= 2'd2;
                            end else if (out_fire) begin
                                state  <= EMPTY;
                                occ_q  <= 2'd0;
                                vld_q  <= 1'b0;
                            end
                        end
                        FULL: begin
                            if (out_fire) begin
                                main_q <= skid_q;
                                state  <= ONE;
                                rdy_q  <= 1'b1;
                                occ_q  <= 2'd1;
                            end
                        end
                        default: begin
                            state  <= EMPTY;
                            rdy_q  <= 1'b1;
                            occ_q  <= 2'd0;
                            vld_q  <= 1'b0;
                        end
                    endcase
                end
            end
        end else begin : g_single
            logic in_fire;

            assign in_ready  = ~vld_q | out_ready;
            assign in_fire   = in_valid & in_ready;
            assign occupancy = {1'b0, vld_q};

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    main_q <= FLUSH_VAL;
                    vld_q  <= 1'b0;
                end else if (flush) begin
                    main_q <= FLUSH_VAL;
                    vld_q  <= 1'b0;
                end else if (in_fire) begin
                    main_q <= in_data;
                    vld_q  <= 1'b1;
                end else if (out_ready) begin
                    vld_q  <= 1'b0;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipe_ctrl_skid.sv
// Drives a skid-buffered and a single-register stage with the same stimulus and
// compares both against a queue-based model of a capacity-limited FIFO.
module tb_pipe_ctrl_skid;

    localparam logic [3:0] FV  = 4'h5;
    localparam logic [2:0] FV3 = 3'b101;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [3:0] in_data;
    logic [2:0] in_data3;
    logic       flush;
    logic       out_ready;

    logic       in_ready1, out_valid1, in_ready0, out_valid0, in_ready3, out_valid3;
    logic [3:0] out_data1, out_data0;
    logic [2:0] out_data3;
    logic [1:0] occupancy1, occupancy0, occupancy3;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Reference: a FIFO of depth 2 (skid) or 1 (single) plus the last value seen on out_data.
    logic [3:0] q1[$];
    logic [3:0] q0[$];
    logic [3:0] last1, last0;

    assign in_data3 = in_data[2:0];

    always #5 clk = ~clk;

    pipe_ctrl_skid #(.WIDTH(4), .FLUSH_VAL(FV), .SKID(1'b1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .flush(flush), .out_valid(out_valid1),
        .out_ready(out_ready), .out_data(out_data1), .occupancy(occupancy1)
    );

    pipe_ctrl_skid #(.WIDTH(4), .FLUSH_VAL(FV), .SKID(1'b0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .flush(flush), .out_valid(out_valid0),
        .out_ready(out_ready), .out_data(out_data0), .occupancy(occupancy0)
    );

    pipe_ctrl_skid #(.WIDTH(3), .FLUSH_VAL(FV3), .SKID(1'b1)) dut3 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready3),
        .in_data(in_data3), .flush(flush), .out_valid(out_valid3),
        .out_ready(out_ready), .out_data(out_data3), .occupancy(occupancy3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0d want=%0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        q1.delete();
        q0.delete();
        last1 = FV;
        last0 = FV;
    endtask

    function automatic logic rdy1_exp();
        return q1.size() < 2;
    endfunction

    function automatic logic rdy0_exp();
        return (q0.size() == 0) || out_ready;
    endfunction

    task automatic compare_all();
        check("valid1", 32'(out_valid1), 32'(q1.size() > 0));
        check("data1",  32'(out_data1),  32'((q1.size() > 0) ? q1[0] : last1));
        check("occ1",   32'(occupancy1), 32'(q1.size()));
        check("ready1", 32'(in_ready1),  32'(rdy1_exp()));
        check("valid0", 32'(out_valid0), 32'(q0.size() > 0));
        check("data0",  32'(out_data0),  32'((q0.size() > 0) ? q0[0] : last0));
        check("occ0",   32'(occupancy0), 32'(q0.size()));
        check("ready0", 32'(in_ready0),  32'(rdy0_exp()));
    endtask

    task automatic check_reset3();
        check("valid3", 32'(out_valid3), 32'd0);
        check("data3",  32'(out_data3),  32'(FV3));
        check("occ3",   32'(occupancy3), 32'd0);
        check("ready3", 32'(in_ready3),  32'd1);
    endtask

    // Applied at the clock edge with the inputs that were stable before it.
    task automatic model_step();
        logic fi1, fo1, fi0, fo0;
        fi1 = in_valid && rdy1_exp() && !flush;
        fo1 = (q1.size() > 0) && out_ready;
        fi0 = in_valid && rdy0_exp() && !flush;
        fo0 = (q0.size() > 0) && out_ready;
        if (flush) begin
            model_reset();
        end else begin
            if (fo1) last1 = q1.pop_front();
            if (fi1) q1.push_back(in_data);
            if (fo0) last0 = q0.pop_front();
            if (fi0) q0.push_back(in_data);
        end
    endtask

    task automatic cycle(input logic iv, input logic [3:0] id, input logic fl,
                         input logic ordy, input logic rst_mid);
        @(negedge clk);
        in_valid  = iv;
        in_data   = id;
        flush     = fl;
        out_ready = ordy;
        #1;
        compare_all();
        if (rst_mid) begin
            #1 reset = 1'b1;
            #1;
            model_reset();
            compare_all();
            check_reset3();
            #1 reset = 1'b0;
        end
        @(posedge clk);
        model_step();
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        compare_all();
        check_reset3();
        reset = 1'b0;

        // idle after release: reset values must hold
        cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        check_reset3();

        // streaming 1..4 with downstream always ready
        for (int unsigned i = 1; i <= 4; i++) cycle(1'b1, 4'(i), 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);

        // backpressure: 6 lands in skid, 7 waits upstream
        cycle(1'b1, 4'd5, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 4'd6, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
        check("bp_occ2", 32'(occupancy1), 32'd2);
        check("bp_rdy0", 32'(in_ready1), 32'd0);
        cycle(1'b1, 4'd7, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 4'd7, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);

        // flush while FULL with a payload offered
        cycle(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'd9, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        check("flush_data1", 32'(out_data1), 32'(FV));

        // single register: hold 4, then release and capture 8 in one cycle
        cycle(1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'd8, 1'b0, 1'b0, 1'b0);
        check("s0_rdy_low", 32'(in_ready0), 32'd0);
        cycle(1'b1, 4'd8, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        check("s0_data8", 32'(out_data0), 32'd8);

        // asynchronous reset between edges while the skid stage is full
        cycle(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'd6, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 4'd2, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);

        // randomized traffic
        for (int unsigned i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 3) != 0),
                  4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 15) == 0),
                  1'($urandom_range(0, 2) != 0),
                  1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_skid.md
# pipe_ctrl_skid

Parametrised pipeline-stage register for control and data fields between CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It generalises the fixed per-bit control registers to a WIDTH-bit payload with a valid/ready handshake, synchronous flush and a configurable flush value. An optional two-entry skid buffer registers the upstream ready, so stall paths do not chain combinationally through the pipeline.

## Interface
- WIDTH, 3, payload width in bits (for example {noflush, regWrite, toReg}); must be ≥ 1.
- FLUSH_VAL, {WIDTH{1'b0}}, value loaded into every data register on reset or flush.
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  reset, asynchronous, active-high.
- in_valid  input  1  upstream payload valid.
- in_ready  output  1  stage can accept the payload this cycle.
- in_data  input  WIDTH  upstream payload.
- flush  input  1  synchronous flush; discards all held entries.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  WIDTH  payload to the next stage.
- occupancy  output  2  number of held entries (0..2; max 1 when SKID=0).

## Operation
- Handshake events:
  - In-fire = in_valid & in_ready.
  - Out-fire = out_valid & out_ready.
- Priority: reset > flush > handshake.
- While flush is high, in_valid is ignored and nothing is captured.
- SKID=1 state machine (state = occupancy):
  - EMPTY (0):
    - in-fire → main ← in_data; go to ONE.
    - otherwise stay.
  - ONE (1):
    - in-fire & out-fire → main ← in_data; stay ONE.
    - in-fire only → skid ← in_data; go to FULL.
    - out-fire only → go to EMPTY.
    - neither → stay.
  - FULL (2):
    - out-fire → main ← skid; go to ONE.
    - otherwise stay.
    - in_ready=0, so in-fire cannot occur.
- SKID=1 outputs:
  - in_ready = (state != FULL), driven from a register.
  - out_valid = (state != EMPTY).
  - out_data = main.
- SKID=0 behaviour:
  - in_ready = ~out_valid | out_ready (combinational).
  - In-fire → main ← in_data, out_valid ← 1.
  - Out-fire without in-fire → out_valid ← 0.
- Flush (either mode), at the next clock edge:
  - state/out_valid cleared to EMPTY.
  - main and skid ← FLUSH_VAL.
  - occupancy ← 0.
  - in_ready ← 1.
- Data registers are not cleared on a normal pop. With out_valid=0, out_data holds the last popped value, or FLUSH_VAL after reset/flush.
- Payload ordering is strictly FIFO. No payload is ever duplicated or dropped except by flush.

## Timing
- Reset (asynchronous) values:
  - out_valid = 0.
  - out_data = FLUSH_VAL.
  - occupancy = 0.
  - in_ready = 1 (SKID=1); in_ready = 1 (SKID=0, because out_valid=0).
- Latency: payload accepted at edge N appears on out_data with out_valid=1 in the cycle after edge N (1 cycle).
- Throughput: 1 payload/cycle sustained while out_ready=1, in both modes.
- SKID=1, out_ready drops:
  - The stage absorbs exactly one more payload into skid.
  - in_ready falls in the cycle after the edge where FULL is entered.
  - in_ready has no combinational path from out_ready.
- SKID=1, out_ready returns in FULL: in_ready rises one cycle after the out-fire edge, when the state returns to ONE.
- Flush coincident with out-fire: the payload is not considered delivered for downstream bookkeeping; downstream must also see flush.
- Flush coincident with in-fire: the payload is dropped.
- Reset asserted mid-transfer: immediate return to reset values. Capture resumes at the first edge after reset deasserts.
- occupancy is registered; it changes only at clock edges or on asynchronous reset.

## Test plan
- Reset, WIDTH=3, FLUSH_VAL=3'b101 → out_valid=0, out_data=3'b101, occupancy=0, in_ready=1; after release, the same values hold with in_valid=0.
- Streaming, SKID=1, out_ready=1, in_data 1,2,3,4 on consecutive cycles → out_data 1,2,3,4 one cycle later, out_valid continuous, occupancy stays 1.
- Backpressure, SKID=1: stream 5,6,7 and drop out_ready while 5 is at the output → 6 lands in skid, occupancy=2, in_ready=0 the next cycle, and 7 is held upstream. Raise out_ready → output 5,6,7 in order with no loss or duplication.
- Flush in FULL, SKID=1, with in_valid=1 and in_data=9 → next cycle occupancy=0, out_valid=0, out_data=FLUSH_VAL, in_ready=1; 9 is never output.
- SKID=0 with out_ready=0 while holding 4 → in_ready=0 combinationally. Set out_ready=1 with in_data=8 in the same cycle → 8 is captured and out_data=8 the next cycle.
- Asynchronous reset pulsed between clock edges while occupancy=2 → outputs return to reset values immediately, without waiting for clk.
